vcve2_vcfg_seq: RTL and testbench
=================================

Name: vcve2_vcfg_seq

Overview:
- Vector configuration and element sequencer for the vcve2 vector extension.
- Holds the vl, vtype and vstart state and executes vsetvl/vsetvli/vsetivli requests from the ID stage.
- Drives a beat-level element iterator that walks elements [vstart, vl) for the vector register file controller.
- Generalises the fixed 32-bit VRF sequencing to parametrised VLEN, ELEN and beat width, and adds fractional LMUL, vill detection and precise vstart tracking.

Parameters:
- VLEN, 128, vector register length in bits; power of 2, 64..1024.
- ELEN, 32, maximum supported SEW in bits; one of 8, 16, 32.
- BEAT_W, 32, datapath bits per iterator beat; power of 2, ELEN..VLEN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- cfg_valid_i  in  1  config request valid.
- cfg_ready_o  out  1  config request accepted.
- cfg_avl_i  in  32  application vector length (rs1 value or uimm).
- cfg_vtype_i  in  32  requested vtype (zimm or rs2).
- cfg_avl_max_i  in  1  rs1=x0, rd!=x0: AVL treated as infinite.
- cfg_keep_vl_i  in  1  rs1=x0, rd=x0: vl unchanged.
- cfg_done_o  out  1  one-cycle pulse; the new vl is valid on cfg_vl_o.
- cfg_vl_o  out  32  new vl, written to rd.
- vstart_we_i  in  1  CSR write to vstart.
- vstart_wdata_i  in  32  vstart write data.
- vl_o  out  32  current vl.
- vtype_o  out  32  current vtype.
- vstart_o  out  32  current vstart.
- vill_o  out  1  vtype.vill.
- iter_start_i  in  1  start an element walk.
- iter_kill_i  in  1  abort the walk (trap or flush).
- iter_busy_o  out  1  walk in progress.
- iter_valid_o  out  1  beat valid.
- iter_ready_i  in  1  beat accepted downstream.
- iter_vreg_off_o  out  3  register offset within the LMUL group.
- iter_byte_off_o  out  log2(VLEN/8)  byte offset of the beat within the register.
- iter_be_o  out  BEAT_W/8  active-byte enables.
- iter_last_o  out  1  final beat.
- iter_done_o  out  1  one-cycle pulse when the walk completes.

Behaviour:
- Reset values:
  - vl_o=0, vstart_o=0, vtype_o=32'h8000_0000, vill_o=1.
  - All pulses 0, iter_valid_o=0, iter_busy_o=0.
  - cfg_ready_o=1 after reset.
- Config path:
  - cfg_ready_o = !iter_busy_o.
  - A request is accepted on cfg_valid_i & cfg_ready_o.
  - vl, vtype, cfg_vl_o and the cfg_done_o pulse appear 1 cycle after acceptance.
  - vstart is cleared to 0 on acceptance.
- vill is set when any of the following holds:
  - vtype[31:8] != 0.
  - vsew > log2(ELEN/8).
  - vlmul == 3'b100.
  - Fractional LMUL with SEW > ELEN*LMUL.
  - On vill: vtype_o=32'h8000_0000, vl=0, cfg_vl_o=0.
- VLMAX = (VLEN/SEW)*LMUL.
  - Fractional LMUL is computed as a right shift.
  - A result of 0 counts as vill.
- vl selection:
  - cfg_keep_vl_i: vl unchanged, clamped to the new VLMAX.
  - cfg_avl_max_i: vl = VLMAX.
  - AVL <= VLMAX: vl = AVL.
  - Otherwise: vl = VLMAX (see the optional feature).
- vstart_we_i:
  - Accepted only when the iterator is idle; ignored while busy.
  - Written value is masked to log2(VLEN) bits.
- Iterator FSM states: IT_IDLE, IT_RUN, IT_FIN.
  - IT_IDLE + iter_start_i, with vill=0 and vstart<vl: enter IT_RUN, idx=vstart.
  - IT_IDLE + iter_start_i, with vill, vl=0 or vstart>=vl: enter IT_FIN with no beats.
  - IT_RUN: iter_valid_o=1. The beat covers the BEAT_W-aligned window containing byte idx*SEW/8.
    - iter_be_o enables bytes of elements e with idx <= e < vl.
    - Global byte offset G: iter_vreg_off_o = G/(VLEN/8), iter_byte_off_o = G mod (VLEN/8).
    - iter_last_o is asserted when the window end reaches vl.
  - On handshake: idx advances to the next window start and vstart_o tracks idx. After the last beat, go to IT_FIN.
  - IT_FIN: iter_done_o pulses, vstart becomes 0, return to IT_IDLE. Total: 1 cycle.
  - iter_kill_i in IT_RUN: return to IT_IDLE next cycle; vstart_o holds the index of the first unaccepted element; no done pulse.
  - iter_kill_i overrides a simultaneous handshake: the beat is not counted.
  - iter_start_i while busy is ignored.
  - iter_busy_o = state != IT_IDLE.
- Asynchronous reset mid-walk or mid-config returns every output to its reset value immediately.

Optional Feature:
- VCVE2_VL_BALANCE_EN.
- Defined: when VLMAX < AVL < 2*VLMAX, vl = ceil(AVL/2).
- Undefined: vl = VLMAX in that range.
- All other vl rules are identical in both builds.

Test Plan:
- Reset: assert rst_i mid-walk -> vl_o=0, vtype_o=32'h8000_0000, vill_o=1, iter_valid_o=0 in the same cycle.
- Config SEW=32, LMUL=1 (VLMAX=4):
  - AVL=10 -> cfg_vl_o=4, cfg_done_o one cycle after acceptance.
  - AVL=6 -> vl=3 with VCVE2_VL_BALANCE_EN, vl=4 without.
- Illegal vtype:
  - vsew=3'b011 (64) -> vill_o=1, vl_o=0.
  - LMUL=1/2 with SEW=32 -> vill.
  - LMUL=1/2 with SEW=16 -> VLMAX=4, legal.
- Walk SEW=8, LMUL=2, vl=17 -> 5 beats with vreg_off 0,0,0,0,1, byte_off 0,4,8,12,0, last be=4'b0001, then iter_done_o and vstart_o=0.
- Walk SEW=16, vl=8, vstart=5 -> beat 1: byte_off 8, be=4'b1100; beat 2: byte_off 12, be=4'b1111, last; done.
- Kill after 2 accepted beats (SEW=32, vl=4, iter_ready_i toggling) -> vstart_o=2, no iter_done_o, cfg_ready_o=1 next cycle.

Source files
------------

// File: rtl/vcve2_vcfg_seq.sv
// vcve2_vcfg_seq: vsetvl* config state and beat-level element sequencer; define VCVE2_VL_BALANCE_EN to balance vl when VLMAX < AVL < 2*VLMAX
module vcve2_vcfg_seq #(
    parameter int VLEN   = 128,
    parameter int ELEN   = 32,
    parameter int BEAT_W = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_valid_i,
    output logic                      cfg_ready_o,
    input  logic [31:0]               cfg_avl_i,
    input  logic [31:0]               cfg_vtype_i,
    input  logic                      cfg_avl_max_i,
    input  logic                      cfg_keep_vl_i,
    output logic                      cfg_done_o,
    output logic [31:0]               cfg_vl_o,
    input  logic                      vstart_we_i,
    input  logic [31:0]               vstart_wdata_i,
    output logic [31:0]               vl_o,
    output logic [31:0]               vtype_o,
    output logic [31:0]               vstart_o,
    output logic                      vill_o,
    input  logic                      iter_start_i,
    input  logic                      iter_kill_i,
    output logic                      iter_busy_o,
    output logic                      iter_valid_o,
    input  logic                      iter_ready_i,
    output logic [2:0]                iter_vreg_off_o,
    output logic [$clog2(VLEN/8)-1:0] iter_byte_off_o,
    output logic [BEAT_W/8-1:0]       iter_be_o,
    output logic                      iter_last_o,
    output logic                      iter_done_o
);
    localparam int VLENB = VLEN / 8;
    localparam int BEATB = BEAT_W / 8;
    localparam int BOW   = $clog2(VLENB);
    localparam int ELW   = $clog2(ELEN / 8);
    localparam logic [31:0] VILL_VTYPE = 32'h8000_0000;

    typedef enum logic [1:0] {IT_IDLE, IT_RUN, IT_FIN} it_state_t;

    it_state_t   state_q, state_d;
    logic [31:0] vl_q, vtype_q, vstart_q, vstart_d, cfg_vl_q;
    logic        cfg_done_q, cfg_accept, vill_n;
    logic [2:0]  vsew_n, vlmul_n, vsew_q;
    logic [31:0] vlen_sew, vlmax, sew_n, elen_frac, over_vl, vl_n;
    logic [31:0] byte_idx, win, win_end, vl_bytes, next_idx;

    assign vsew_n     = cfg_vtype_i[5:3];
    assign vlmul_n    = cfg_vtype_i[2:0];
    assign vlen_sew   = 32'(VLEN) >> (4'd3 + {1'b0, vsew_n});
    assign vlmax      = vlmul_n[2] ? vlen_sew >> (4'd8 - {1'b0, vlmul_n}) : vlen_sew << vlmul_n[1:0];
    assign sew_n      = 32'd8 << vsew_n;
    assign elen_frac  = 32'(ELEN) >> (4'd8 - {1'b0, vlmul_n});
    assign vill_n     = (|cfg_vtype_i[31:8]) || (vsew_n > 3'(ELW)) || (vlmul_n == 3'b100) ||
                        (vlmul_n[2] && sew_n > elen_frac) || (vlmax == 32'd0);
`ifdef VCVE2_VL_BALANCE_EN
    assign over_vl    = ({1'b0, cfg_avl_i} < {vlmax, 1'b0}) ? (cfg_avl_i >> 1) + {31'd0, cfg_avl_i[0]} : vlmax;
`else
    assign over_vl    = vlmax;
`endif
    assign vl_n       = vill_n ? 32'd0 :
                        cfg_keep_vl_i ? (vl_q < vlmax ? vl_q : vlmax) :
                        cfg_avl_max_i ? vlmax :
                        (cfg_avl_i <= vlmax) ? cfg_avl_i : over_vl;

    assign iter_busy_o = state_q != IT_IDLE;
    assign cfg_ready_o = !iter_busy_o;
    assign cfg_accept  = cfg_valid_i && cfg_ready_o;
    assign cfg_done_o  = cfg_done_q;
    assign cfg_vl_o    = cfg_vl_q;
    assign vl_o        = vl_q;
    assign vtype_o     = vtype_q;
    assign vill_o      = vtype_q[31];
    assign vstart_o    = vstart_q;

    assign vsew_q          = vtype_q[5:3];
    assign byte_idx        = vstart_q << vsew_q;
    assign win             = byte_idx & ~(32'(BEATB) - 32'd1);
    assign win_end         = win + 32'(BEATB);
    assign vl_bytes        = vl_q << vsew_q;
    assign next_idx        = win_end >> vsew_q;
    assign iter_last_o     = win_end >= vl_bytes;
    assign iter_vreg_off_o = win[BOW+2:BOW];
    assign iter_byte_off_o = win[BOW-1:0];

    // byte enables: bytes of the window belonging to elements in [idx, vl)
    always_comb begin
        iter_be_o = '0;
        for (int k = 0; k < BEATB; k++) iter_be_o[k] = (win + 32'(k) >= byte_idx) && (win + 32'(k) < vl_bytes);
    end

    // config state: vl/vtype update and done pulse one cycle after acceptance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vl_q       <= '0;
            vtype_q    <= VILL_VTYPE;
            cfg_vl_q   <= '0;
            cfg_done_q <= 1'b0;
        end else begin
            cfg_done_q <= cfg_accept;
            if (cfg_accept) begin
                vl_q     <= vl_n;
                cfg_vl_q <= vl_n;
                vtype_q  <= vill_n ? VILL_VTYPE : cfg_vtype_i;
            end
        end
    end

    // iterator state and vstart (which doubles as the walk index)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IT_IDLE;
            vstart_q <= '0;
        end else begin
            state_q  <= state_d;
            vstart_q <= vstart_d;
        end
    end

    // iterator next state, vstart update and beat handshake
    always_comb begin
        state_d      = state_q;
        vstart_d     = vstart_q;
        iter_valid_o = 1'b0;
        iter_done_o  = 1'b0;
        case (state_q)
            IT_IDLE: begin
                if (iter_start_i) state_d = (!vill_o && vstart_q < vl_q) ? IT_RUN : IT_FIN;
                else if (cfg_accept) vstart_d = '0;
                else if (vstart_we_i) vstart_d = vstart_wdata_i & 32'(VLEN - 1);
            end
            IT_RUN: begin
                iter_valid_o = 1'b1;
                if (iter_kill_i) state_d = IT_IDLE;
                else if (iter_ready_i) begin
                    vstart_d = next_idx;
                    state_d  = iter_last_o ? IT_FIN : IT_RUN;
                end
            end
            IT_FIN: begin
                iter_done_o = 1'b1;
                vstart_d    = '0;
                state_d     = IT_IDLE;
            end
            default: state_d = IT_IDLE;
        endcase
    end
endmodule

// File: tb/tb_vcve2_vcfg_seq.sv
// tb_vcve2_vcfg_seq: directed self-checking bench for vcve2_vcfg_seq (VLEN=128, ELEN=32, BEAT_W=32)
module tb_vcve2_vcfg_seq;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        cfg_valid_i = 0, cfg_avl_max_i = 0, cfg_keep_vl_i = 0;
    logic [31:0] cfg_avl_i = 0, cfg_vtype_i = 0, vstart_wdata_i = 0;
    logic        vstart_we_i = 0, iter_start_i = 0, iter_kill_i = 0, iter_ready_i = 0;
    logic        cfg_ready_o, cfg_done_o, vill_o, iter_busy_o, iter_valid_o, iter_last_o, iter_done_o;
    logic [31:0] cfg_vl_o, vl_o, vtype_o, vstart_o;
    logic [2:0]  iter_vreg_off_o;
    logic [3:0]  iter_byte_off_o;
    logic [3:0]  iter_be_o;
    int n_cmp = 0, n_err = 0;

    vcve2_vcfg_seq dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_avl_i(cfg_avl_i),
        .cfg_vtype_i(cfg_vtype_i), .cfg_avl_max_i(cfg_avl_max_i), .cfg_keep_vl_i(cfg_keep_vl_i),
        .cfg_done_o(cfg_done_o), .cfg_vl_o(cfg_vl_o),
        .vstart_we_i(vstart_we_i), .vstart_wdata_i(vstart_wdata_i),
        .vl_o(vl_o), .vtype_o(vtype_o), .vstart_o(vstart_o), .vill_o(vill_o),
        .iter_start_i(iter_start_i), .iter_kill_i(iter_kill_i), .iter_busy_o(iter_busy_o),
        .iter_valid_o(iter_valid_o), .iter_ready_i(iter_ready_i),
        .iter_vreg_off_o(iter_vreg_off_o), .iter_byte_off_o(iter_byte_off_o),
        .iter_be_o(iter_be_o), .iter_last_o(iter_last_o), .iter_done_o(iter_done_o)
    );

    always #5 clk_i = ~clk_i;

    // issue one config request at a negedge; returns at the negedge after acceptance
    task automatic cfg(input logic [31:0] avl, input logic [31:0] vt, input logic amax, input logic keep);
        cfg_valid_i = 1; cfg_avl_i = avl; cfg_vtype_i = vt; cfg_avl_max_i = amax; cfg_keep_vl_i = keep;
        @(negedge clk_i);
        cfg_valid_i = 0; cfg_avl_max_i = 0; cfg_keep_vl_i = 0;
    endtask

    task automatic write_vstart(input logic [31:0] d);
        vstart_we_i = 1; vstart_wdata_i = d;
        @(negedge clk_i);
        vstart_we_i = 0;
    endtask

    task automatic start_walk();
        iter_start_i = 1;
        @(negedge clk_i);
        iter_start_i = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        n_cmp++; if (vl_o !== 32'd0) begin n_err++; $display("FAIL rst_vl got %h want 0", vl_o); end
        n_cmp++; if (vtype_o !== 32'h8000_0000) begin n_err++; $display("FAIL rst_vtype got %h want 80000000", vtype_o); end
        n_cmp++; if (vill_o !== 1'b1) begin n_err++; $display("FAIL rst_vill got %b want 1", vill_o); end
        n_cmp++; if (vstart_o !== 32'd0) begin n_err++; $display("FAIL rst_vstart got %h want 0", vstart_o); end
        n_cmp++; if ({cfg_ready_o, iter_busy_o, iter_valid_o, iter_done_o, cfg_done_o} !== 5'b10000) begin
            n_err++; $display("FAIL rst_flags got %b want 10000", {cfg_ready_o, iter_busy_o, iter_valid_o, iter_done_o, cfg_done_o}); end
        rst_i = 0;
        @(negedge clk_i);
    endtask

    task automatic test_cfg_basic();
        write_vstart(32'd3);
        n_cmp++; if (vstart_o !== 32'd3) begin n_err++; $display("FAIL vstart_wr got %h want 3", vstart_o); end
        n_cmp++; if (cfg_done_o !== 1'b0) begin n_err++; $display("FAIL done_idle got %b want 0", cfg_done_o); end
        cfg(32'd10, 32'h10, 0, 0);
        n_cmp++; if (cfg_done_o !== 1'b1) begin n_err++; $display("FAIL cfg_done got %b want 1", cfg_done_o); end
        n_cmp++; if (cfg_vl_o !== 32'd4) begin n_err++; $display("FAIL cfg_vl_avl10 got %0d want 4", cfg_vl_o); end
        n_cmp++; if (vl_o !== 32'd4) begin n_err++; $display("FAIL vl_avl10 got %0d want 4", vl_o); end
        n_cmp++; if ({vill_o, vtype_o} !== {1'b0, 32'h10}) begin n_err++; $display("FAIL vtype_e32 got %b/%h want 0/10", vill_o, vtype_o); end
        n_cmp++; if (vstart_o !== 32'd0) begin n_err++; $display("FAIL vstart_clr got %h want 0", vstart_o); end
        @(negedge clk_i);
        n_cmp++; if (cfg_done_o !== 1'b0) begin n_err++; $display("FAIL cfg_done_pulse got %b want 0", cfg_done_o); end
    endtask

    task automatic test_vl_select();
        logic [31:0] exp6;
`ifdef VCVE2_VL_BALANCE_EN
        exp6 = 32'd3;
`else
        exp6 = 32'd4;
`endif
        cfg(32'd6, 32'h10, 0, 0);
        n_cmp++; if (vl_o !== exp6) begin n_err++; $display("FAIL vl_avl6 got %0d want %0d", vl_o, exp6); end
        cfg(32'd3, 32'h10, 0, 0);
        n_cmp++; if (vl_o !== 32'd3) begin n_err++; $display("FAIL vl_avl3 got %0d want 3", vl_o); end
        cfg(32'd0, 32'h10, 1, 0);
        n_cmp++; if (vl_o !== 32'd4) begin n_err++; $display("FAIL vl_avlmax got %0d want 4", vl_o); end
        cfg(32'd8, 32'h08, 0, 0);
        n_cmp++; if (vl_o !== 32'd8) begin n_err++; $display("FAIL vl_e16 got %0d want 8", vl_o); end
        cfg(32'd99, 32'h10, 0, 1);
        n_cmp++; if (cfg_vl_o !== 32'd4) begin n_err++; $display("FAIL vl_keep_clamp got %0d want 4", cfg_vl_o); end
    endtask

    task automatic test_illegal();
        cfg(32'd4, 32'h18, 0, 0);
        n_cmp++; if ({vill_o, vl_o, vtype_o} !== {1'b1, 32'd0, 32'h8000_0000}) begin
            n_err++; $display("FAIL vill_sew64 got %b/%0d/%h want 1/0/80000000", vill_o, vl_o, vtype_o); end
        cfg(32'd2, 32'h17, 0, 0);
        n_cmp++; if ({vill_o, cfg_vl_o} !== {1'b1, 32'd0}) begin n_err++; $display("FAIL vill_mf2_e32 got %b/%0d want 1/0", vill_o, cfg_vl_o); end
        cfg(32'd2, 32'h14, 0, 0);
        n_cmp++; if (vill_o !== 1'b1) begin n_err++; $display("FAIL vill_lmul100 got %b want 1", vill_o); end
        cfg(32'd2, 32'h110, 0, 0);
        n_cmp++; if (vill_o !== 1'b1) begin n_err++; $display("FAIL vill_hibits got %b want 1", vill_o); end
        start_walk();
        n_cmp++; if ({iter_valid_o, iter_done_o, iter_busy_o} !== 3'b011) begin
            n_err++; $display("FAIL vill_walk got %b want 011", {iter_valid_o, iter_done_o, iter_busy_o}); end
        @(negedge clk_i);
        cfg(32'd100, 32'h0F, 0, 0);
        n_cmp++; if ({vill_o, vl_o} !== {1'b0, 32'd4}) begin n_err++; $display("FAIL mf2_e16 got %b/%0d want 0/4", vill_o, vl_o); end
    endtask

    task automatic test_walk_e8_m2();
        logic [2:0] ev[5] = '{0, 0, 0, 0, 1};
        logic [3:0] eb[5] = '{0, 4, 8, 12, 0};
        logic [3:0] ee[5] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h1};
        cfg(32'd17, 32'h01, 0, 0);
        n_cmp++; if (vl_o !== 32'd17) begin n_err++; $display("FAIL walk8_vl got %0d want 17", vl_o); end
        iter_ready_i = 1;
        start_walk();
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({iter_valid_o, iter_vreg_off_o, iter_byte_off_o, iter_be_o, iter_last_o, cfg_ready_o} !== {1'b1, ev[i], eb[i], ee[i], i == 4, 1'b0}) begin
                n_err++; $display("FAIL walk8_beat%0d got v%b r%0d o%0d be%h l%b cr%b want r%0d o%0d be%h", i, iter_valid_o,
                                  iter_vreg_off_o, iter_byte_off_o, iter_be_o, iter_last_o, cfg_ready_o, ev[i], eb[i], ee[i]); end
            n_cmp++; if (vstart_o !== 32'(i * 4)) begin n_err++; $display("FAIL walk8_vstart%0d got %0d want %0d", i, vstart_o, i * 4); end
            @(negedge clk_i);
        end
        n_cmp++; if ({iter_valid_o, iter_done_o} !== 2'b01) begin n_err++; $display("FAIL walk8_done got %b want 01", {iter_valid_o, iter_done_o}); end
        @(negedge clk_i);
        n_cmp++; if ({vstart_o, iter_busy_o, iter_done_o} !== {32'd0, 2'b00}) begin
            n_err++; $display("FAIL walk8_end got %0d/%b/%b want 0/0/0", vstart_o, iter_busy_o, iter_done_o); end
        iter_ready_i = 0;
    endtask

    task automatic test_walk_vstart();
        cfg(32'd8, 32'h08, 0, 0);
        write_vstart(32'hFFFF_FF85);
        n_cmp++; if (vstart_o !== 32'd5) begin n_err++; $display("FAIL vstart_mask got %h want 5", vstart_o); end
        start_walk();
        vstart_we_i = 1; vstart_wdata_i = 32'd1;
        @(negedge clk_i);
        vstart_we_i = 0;
        n_cmp++; if ({iter_valid_o, iter_byte_off_o, iter_be_o, iter_last_o, vstart_o} !== {1'b1, 4'd8, 4'b1100, 1'b0, 32'd5}) begin
            n_err++; $display("FAIL vs_beat1 got v%b o%0d be%b l%b vs%0d want v1 o8 be1100 l0 vs5", iter_valid_o, iter_byte_off_o, iter_be_o, iter_last_o, vstart_o); end
        iter_ready_i = 1;
        @(negedge clk_i);
        n_cmp++; if ({iter_valid_o, iter_byte_off_o, iter_be_o, iter_last_o, vstart_o} !== {1'b1, 4'd12, 4'b1111, 1'b1, 32'd6}) begin
            n_err++; $display("FAIL vs_beat2 got v%b o%0d be%b l%b vs%0d want v1 o12 be1111 l1 vs6", iter_valid_o, iter_byte_off_o, iter_be_o, iter_last_o, vstart_o); end
        @(negedge clk_i);
        iter_ready_i = 0;
        n_cmp++; if (iter_done_o !== 1'b1) begin n_err++; $display("FAIL vs_done got %b want 1", iter_done_o); end
        @(negedge clk_i);
    endtask

    task automatic test_kill();
        cfg(32'd4, 32'h10, 0, 0);
        start_walk();
        iter_ready_i = 1; @(negedge clk_i);
        iter_ready_i = 0; @(negedge clk_i);
        iter_ready_i = 1; @(negedge clk_i);
        n_cmp++; if ({iter_valid_o, vstart_o} !== {1'b1, 32'd2}) begin n_err++; $display("FAIL kill_pre got %b/%0d want 1/2", iter_valid_o, vstart_o); end
        iter_kill_i = 1; @(negedge clk_i);
        iter_kill_i = 0; iter_ready_i = 0;
        n_cmp++; if ({vstart_o, iter_busy_o, iter_valid_o, iter_done_o, cfg_ready_o} !== {32'd2, 4'b0001}) begin
            n_err++; $display("FAIL kill_post got vs%0d b%b v%b d%b cr%b want vs2 b0 v0 d0 cr1", vstart_o, iter_busy_o, iter_valid_o, iter_done_o, cfg_ready_o); end
        @(negedge clk_i);
        n_cmp++; if ({iter_done_o, vstart_o} !== {1'b0, 32'd2}) begin n_err++; $display("FAIL kill_nodone got %b/%0d want 0/2", iter_done_o, vstart_o); end
    endtask

    task automatic test_reset_midwalk();
        cfg(32'd4, 32'h10, 0, 0);
        start_walk();
        n_cmp++; if (iter_valid_o !== 1'b1) begin n_err++; $display("FAIL mid_valid got %b want 1", iter_valid_o); end
        rst_i = 1; #1;
        n_cmp++; if ({vl_o, vtype_o, vill_o, iter_valid_o, iter_busy_o, cfg_ready_o} !== {32'd0, 32'h8000_0000, 4'b1001}) begin
            n_err++; $display("FAIL mid_reset got vl%0d vt%h vill%b v%b b%b cr%b want 0/80000000/1/0/0/1", vl_o, vtype_o, vill_o, iter_valid_o, iter_busy_o, cfg_ready_o); end
        @(negedge clk_i);
        rst_i = 0;
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_cfg_basic();
        test_vl_select();
        test_illegal();
        test_walk_e8_m2();
        test_walk_vstart();
        test_kill();
        test_reset_midwalk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
